traffic_phase_scheduler: RTL
============================

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter CLK_HZ, 50000000, clock cycles per one-second tick.
REQ-002 Parameter T_GREEN, 25, green duration in seconds.
REQ-003 Parameter T_YELLOW, 3, yellow duration in seconds.
REQ-004 Parameter T_ALLRED, 2, all-red clearance duration in seconds.
REQ-005 Parameter T_WALK, 10, pedestrian walk duration in seconds.
REQ-006 clk50M  in  1  sole clock; one clock, all logic on its rising edge.
REQ-007 Reset  in  1  reset, synchronous and active-low.
REQ-008 S1, S2  in  1 each  vehicle-presence sensor, road 1 / road 2, level.
REQ-009 PB  in  1  pedestrian button, any-width pulse.
REQ-010 LR1, LY1, LG1, LR2, LY2, LG2  out  1 each  lamp drives, registered.
REQ-011 WALK  out  1  pedestrian walk lamp, registered.
REQ-012 remain  out  8  seconds left in current phase, unsigned, for the HEX display driver.
REQ-013 phase  out  3  state code: 0 AR_INIT, 1 G1, 2 Y1, 3 AR1, 4 G2, 5 Y2, 6 AR2, 7 WALK.

Function
REQ-014 sec_tick SHALL pulse for one cycle every CLK_HZ cycles; divider counter wraps from CLK_HZ-1 to 0.
REQ-015 remain SHALL decrement by 1 only on cycles with sec_tick=1, saturating at 0.
REQ-016 Transition SHALL occur on the edge where sec_tick=1 and remain<=1; the new state loads remain with its duration on that same edge.
REQ-017 Order: AR_INIT->G1->Y1->AR1->G2->Y2->AR2->G1, with WALK inserted per REQ-021.
REQ-018 Durations: G1/G2 T_GREEN, Y1/Y2 T_YELLOW, AR_INIT/AR1/AR2 T_ALLRED, WALK T_WALK.
REQ-019 G1 SHALL leave only if S2 or ped_pending is 1 at the expiry tick; otherwise it rests: remain=0, LG1 held, and it exits on the first sec_tick with demand present. G2 mirrors this with S1.
REQ-020 ped_pending SHALL set on any cycle with PB=1 outside WALK and clear on the edge entering WALK; PB during WALK SHALL be ignored.
REQ-021 At AR1 or AR2 expiry with ped_pending=1, next state SHALL be WALK; WALK expiry SHALL proceed to the green that would have followed (G2 after AR1, G1 after AR2).
REQ-022 Lamp decode: exactly one of LRx/LYx/LGx high per road in every state; red on both roads in AR_INIT, AR1, AR2, WALK; WALK=1 only in state WALK.
REQ-023 Outputs SHALL change on the same edge as the state register, with no combinational path from inputs.
REQ-024 S1/S2 changes mid-phase SHALL NOT shorten any phase.

Reset
REQ-025 With Reset=0 at an edge: state AR_INIT, remain=T_ALLRED, LR1=LR2=1, all other lamps 0, WALK=0, phase=0, ped_pending=0, divider=0.
REQ-026 Reset SHALL override all activity, mid-phase included; the first sec_tick after release occurs CLK_HZ cycles later.

Configuration
REQ-027 Macro PED_PHASE_EN defined: PB, ped_pending and WALK state present per REQ-020/021.
REQ-028 PED_PHASE_EN undefined: PB ignored, WALK tied 0, state 7 unreachable, green demand from the opposite sensor only.

Verification (CLK_HZ=4, other parameters at default)
REQ-029 Reset=0 for 2 cycles, then 1 -> LR1=LR2=1, remain=2; after 8 cycles, phase=1, LG1=1, remain=25.
REQ-030 S2=1 held -> G1 for 25 ticks, Y1 for 3, AR1 for 2, then G2 with LG2=1, remain=25.
REQ-031 S1=S2=0, PB=0 -> G1 rests: remain=0, LG1=1 for 100 ticks; S2=1 -> Y1 on the next sec_tick.
REQ-032 1-cycle PB during G1, S2=0 -> G1->Y1->AR1->WALK (WALK=1, remain=10, LR1=LR2=1)->G2; second PB during WALK -> no further WALK.
REQ-033 Reset=0 mid-Y2 -> next edge phase=0, remain=2, ped_pending=0, LY2=0.
REQ-034 Build without PED_PHASE_EN, PB pulse in G1 with S1=S2=0 -> G1 rests indefinitely, WALK=0 throughout.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Two-road traffic phase scheduler with a one-second timebase and sensor-gated greens.
// Defining PED_PHASE_EN adds the pedestrian button, pending latch and WALK phase.
module traffic_phase_scheduler #(
    parameter int CLK_HZ   = 50000000,
    parameter int T_GREEN  = 25,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 2,
    parameter int T_WALK   = 10
) (
    input  logic       clk50M,
    input  logic       Reset,
    input  logic       S1,
    input  logic       S2,
    input  logic       PB,
    output logic       LR1,
    output logic       LY1,
    output logic       LG1,
    output logic       LR2,
    output logic       LY2,
    output logic       LG2,
    output logic       WALK,
    output logic [7:0] remain,
    output logic [2:0] phase
);

    localparam logic [2:0] ST_AR_INIT = 3'd0;
    localparam logic [2:0] ST_G1      = 3'd1;
    localparam logic [2:0] ST_Y1      = 3'd2;
    localparam logic [2:0] ST_AR1     = 3'd3;
    localparam logic [2:0] ST_G2      = 3'd4;
    localparam logic [2:0] ST_Y2      = 3'd5;
    localparam logic [2:0] ST_AR2     = 3'd6;
    localparam logic [2:0] ST_WALK    = 3'd7;

    localparam int               DIV_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             sec_tick;
    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [7:0]       remain_nx;
    logic             adv;
    logic             ped_pending;
    logic             ret_g2;

    function automatic logic [7:0] sat_dec(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

    function automatic logic [7:0] phase_dur(input logic [2:0] st);
        case (st)
            ST_G1, ST_G2: phase_dur = 8'(T_GREEN);
            ST_Y1, ST_Y2: phase_dur = 8'(T_YELLOW);
            ST_WALK:      phase_dur = 8'(T_WALK);
            default:      phase_dur = 8'(T_ALLRED);
        endcase
    endfunction

    // Lamp vector order: {LR1, LY1, LG1, LR2, LY2, LG2, WALK}
    function automatic logic [6:0] lamp_dec(input logic [2:0] st);
        case (st)
            ST_G1:   lamp_dec = 7'b001_100_0;
            ST_Y1:   lamp_dec = 7'b010_100_0;
            ST_G2:   lamp_dec = 7'b100_001_0;
            ST_Y2:   lamp_dec = 7'b100_010_0;
            ST_WALK: lamp_dec = 7'b100_100_1;
            default: lamp_dec = 7'b100_100_0;
        endcase
    endfunction

    assign sec_tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk50M) begin
        if (!Reset) begin
            div_cnt <= '0;
        end else if (sec_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

`ifdef PED_PHASE_EN
    // Button latch; cleared by the very edge that enters WALK, deaf while in WALK.
    always_ff @(posedge clk50M) begin
        if (!Reset) begin
            ped_pending <= 1'b0;
        end else if (state_nx == ST_WALK && state != ST_WALK) begin
            ped_pending <= 1'b0;
        end else if (PB && state != ST_WALK) begin
            ped_pending <= 1'b1;
        end
    end
`else
    logic unused_pb;
    assign unused_pb   = PB;
    assign ped_pending = 1'b0;
`endif

    // A green whose timer ran out without demand rests at remain=0 until demand appears.
    always_comb begin
        state_nx = state;
        if (sec_tick && remain <= 8'd1) begin
            case (state)
                ST_AR_INIT: state_nx = ST_G1;
                ST_G1:      if (S2 || ped_pending) state_nx = ST_Y1;
                ST_Y1:      state_nx = ST_AR1;
                ST_AR1:     state_nx = ped_pending ? ST_WALK : ST_G2;
                ST_G2:      if (S1 || ped_pending) state_nx = ST_Y2;
                ST_Y2:      state_nx = ST_AR2;
                ST_AR2:     state_nx = ped_pending ? ST_WALK : ST_G1;
                ST_WALK:    state_nx = ret_g2 ? ST_G2 : ST_G1;
                default:    state_nx = ST_AR_INIT;
            endcase
        end
        adv = (state_nx != state);
        if (adv) begin
            remain_nx = phase_dur(state_nx);
        end else if (sec_tick) begin
            remain_nx = sat_dec(remain);
        end else begin
            remain_nx = remain;
        end
    end

    // Lamps decode the next state so they switch on the same edge as the state register.
    always_ff @(posedge clk50M) begin
        if (!Reset) begin
            state  <= ST_AR_INIT;
            remain <= 8'(T_ALLRED);
            ret_g2 <= 1'b0;
            {LR1, LY1, LG1, LR2, LY2, LG2, WALK} <= lamp_dec(ST_AR_INIT);
        end else begin
            state  <= state_nx;
            remain <= remain_nx;
            {LR1, LY1, LG1, LR2, LY2, LG2, WALK} <= lamp_dec(state_nx);
            if (state_nx == ST_WALK && state != ST_WALK) begin
                ret_g2 <= (state == ST_AR1);
            end
        end
    end

    assign phase = state;

endmodule
